dsc_mul_seq: RTL and testbench
==============================

DSC_MUL_SEQ -- requirements
Module: dsc_mul_seq

Interface
REQ-001 SHALL have parameter SNG_WIDTH, default 6, operand width in bits.
REQ-002 SHALL have parameter NUM_INPUTS, default 2, operand count; result width RW = NUM_INPUTS*SNG_WIDTH.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports in_valid  in  1 / in_ready  out  1  operand handshake.
REQ-006 SHALL have ports in_a, in_b  in  SNG_WIDTH  binary operands.
REQ-007 SHALL have ports core_a, core_b  out  SNG_WIDTH  operands held to the multiplier core.
REQ-008 SHALL have ports core_en  out  1 / core_clr  out  1  core enable and active-high core clear.
REQ-009 SHALL have ports core_z  in  RW  core result count / core_ov  in  1  core stop indication.
REQ-010 SHALL have ports out_valid  out  1 / out_ready  in  1 / out_z  out  RW  result handshake and product.
REQ-011 SHALL have port out_cycles  out  RW+1  number of RUN cycles used.

Function
REQ-012 SHALL implement FSM states IDLE, CLEAR, RUN, CAPTURE, HOLD.
REQ-013 IDLE: in_ready=1; in_valid&in_ready registers in_a/in_b onto core_a/core_b and moves to CLEAR.
REQ-014 CLEAR: core_clr=1 for exactly one cycle, core_en=0, run counter cleared to 0; next state RUN.
REQ-015 RUN: core_en=1; run counter increments by 1 every cycle.
REQ-016 RUN SHALL exit to CAPTURE when the counter reaches 2^RW (full deterministic period, 4096 at defaults).
REQ-017 CAPTURE: core_en=0; core_z registered to out_z, counter value to out_cycles; next state HOLD.
REQ-018 HOLD: out_valid=1, out_z/out_cycles stable; out_valid&out_ready returns to IDLE.
REQ-019 in_ready SHALL be 0 in every state except IDLE; no operand is accepted back-to-back with a held result.
REQ-020 out_valid SHALL not drop without out_ready; out_ready outside HOLD is ignored.
REQ-021 Operand zero (in_a=0 or in_b=0) SHALL still run the full sequence; out_z=0.
REQ-022 Latency from in handshake to out_valid SHALL be 1 (CLEAR) + N (RUN) + 1 (CAPTURE) cycles, N = out_cycles.
REQ-023 core_a/core_b SHALL remain constant from CLEAR through CAPTURE.

Reset
REQ-024 rst low SHALL asynchronously force state IDLE, in_ready=1, out_valid=0, core_en=0, core_clr=1, core_a=core_b=0, out_z=0, out_cycles=0.
REQ-025 core_clr SHALL deassert on the first clock edge after rst rises; reset mid-RUN discards the operation with no out_valid.

Configuration
REQ-026 Macro DSC_EARLY_SHUTOFF_EN SHALL control early termination.
REQ-027 With DSC_EARLY_SHUTOFF_EN defined: RUN exits to CAPTURE on the first cycle core_ov=1 (counter >= 1), or at 2^RW, whichever is first.
REQ-028 Without it: core_ov is ignored; RUN always lasts exactly 2^RW cycles.
REQ-029 core_ov and counter terminal occurring in the same cycle SHALL be one exit; out_cycles reflects the counter at exit.

Structure
REQ-030 Package dsc_pkg SHALL hold SNG_WIDTH/NUM_INPUTS defaults and the FSM state enum.
REQ-031 Run counter SHALL be a sub-module dsc_run_ctr (RW+1 bits, clear, enable, terminal flag).
REQ-032 All outputs SHALL be registered; no combinational path from in_valid or out_ready to outputs except in_ready/out_valid state decode.

Verification
REQ-033 Macro off, in_a=32, in_b=32 with reference core -> out_z=1024, out_cycles=4096, out_valid 4098 cycles after handshake.
REQ-034 Macro off, in_a=63, in_b=63 -> out_z=3969, out_cycles=4096; in_a=0, in_b=45 -> out_z=0, out_cycles=4096.
REQ-035 Macro on, core_ov forced high on RUN cycle 10 -> out_cycles=10, out_z=core_z sampled that cycle.
REQ-036 out_ready held low 20 cycles in HOLD -> out_valid, out_z stable; in_valid pulses ignored (in_ready=0).
REQ-037 rst low at RUN cycle 100 -> IDLE immediately, core_en=0, out_valid never asserted; next operand pair completes normally.
REQ-038 Two back-to-back operand pairs with out_ready=1 -> two results in order, each exact product.

Source files
------------

// File: rtl/dsc_pkg.sv
// dsc_pkg: shared defaults and FSM state type for the sequential
// stochastic multiplier controller (dsc_mul_seq, dsc_run_ctr).
package dsc_pkg;

  localparam int SNG_WIDTH_DEF  = 6;
  localparam int NUM_INPUTS_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4
  } dsc_state_e;

endpackage

// File: rtl/dsc_run_ctr.sv
// dsc_run_ctr: RUN-cycle counter, W+1 bits wide so it can hold 2^W.
// Ports: clk, rst (async low), clr, en, cnt, term (next count is 2^W).
module dsc_run_ctr
  import dsc_pkg::*;
#(
  parameter int W = NUM_INPUTS_DEF * SNG_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W:0]   cnt,
  output logic         term
);

  localparam logic [W:0] LAST = {1'b0, {W{1'b1}}};

  // term flags the increment that lands on 2^W
  assign term = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dsc_mul_seq.sv
// dsc_mul_seq: sequences a stochastic multiplier core through a full
// deterministic period (2^RW cycles) and returns the product count.
// Ports: clk, rst (async low), in_valid/in_ready/in_a/in_b,
// core_a/core_b/core_en/core_clr/core_z/core_ov,
// out_valid/out_ready/out_z/out_cycles.
// Option: DSC_EARLY_SHUTOFF_EN lets core_ov end RUN early.
module dsc_mul_seq
  import dsc_pkg::*;
#(
  parameter  int SNG_WIDTH  = SNG_WIDTH_DEF,
  parameter  int NUM_INPUTS = NUM_INPUTS_DEF,
  localparam int RW         = NUM_INPUTS * SNG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SNG_WIDTH-1:0] in_a,
  input  logic [SNG_WIDTH-1:0] in_b,
  output logic [SNG_WIDTH-1:0] core_a,
  output logic [SNG_WIDTH-1:0] core_b,
  output logic                 core_en,
  output logic                 core_clr,
  input  logic [RW-1:0]        core_z,
  input  logic                 core_ov,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RW-1:0]        out_z,
  output logic [RW:0]          out_cycles
);

  dsc_state_e state;
  dsc_state_e next;

  logic        ctr_clr;
  logic        ctr_en;
  logic [RW:0] cnt;
  logic        run_term;
  logic        ov_hit;

  assign ctr_clr = (state == ST_CLEAR);
  assign ctr_en  = (state == ST_RUN);

  dsc_run_ctr #(
    .W (RW)
  ) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (ctr_clr),
    .en   (ctr_en),
    .cnt  (cnt),
    .term (run_term)
  );

`ifdef DSC_EARLY_SHUTOFF_EN
  // first RUN cycle ignores core_ov: core state is still fresh
  assign ov_hit = core_ov && (cnt != '0);
`else
  logic unused_ov;
  assign unused_ov = core_ov;
  assign ov_hit    = 1'b0;
`endif

  always_comb begin
    next = state;
    unique case (state)
      ST_IDLE:    if (in_valid) next = ST_CLEAR;
      ST_CLEAR:   next = ST_RUN;
      ST_RUN:     if (run_term || ov_hit) next = ST_CAPTURE;
      ST_CAPTURE: next = ST_HOLD;
      ST_HOLD:    if (out_ready) next = ST_IDLE;
      default:    next = ST_IDLE;
    endcase
  end

  // every output is a register loaded from the next-state decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      core_en    <= 1'b0;
      core_clr   <= 1'b1;
      core_a     <= '0;
      core_b     <= '0;
      out_z      <= '0;
      out_cycles <= '0;
    end else begin
      state     <= next;
      in_ready  <= (next == ST_IDLE);
      out_valid <= (next == ST_HOLD);
      core_en   <= (next == ST_RUN);
      core_clr  <= (next == ST_CLEAR);
      if (state == ST_IDLE && in_valid) begin
        core_a <= in_a;
        core_b <= in_b;
      end
      if (state == ST_CAPTURE) begin
        out_z      <= core_z;
        out_cycles <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_dsc_mul_seq.sv
// tb_dsc_mul_seq: directed bench for dsc_mul_seq with a unary
// comparator reference core (full period count equals a*b).
module tb_dsc_mul_seq;

  localparam int SW = 6;
  localparam int NI = 2;
  localparam int RW = SW * NI;

`ifdef DSC_EARLY_SHUTOFF_EN
  localparam int OV_CYC = 10;
  localparam int OV_Z   = 10;
`else
  localparam int OV_CYC = 4096;
  localparam int OV_Z   = 60;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_a;
  logic [SW-1:0] in_b;
  logic [SW-1:0] core_a;
  logic [SW-1:0] core_b;
  logic          core_en;
  logic          core_clr;
  logic [RW-1:0] core_z;
  logic          core_ov;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_z;
  logic [RW:0]   out_cycles;

  int errors = 0;
  int checks = 0;
  int lat;

  always #5 clk = ~clk;

  dsc_mul_seq #(
    .SNG_WIDTH  (SW),
    .NUM_INPUTS (NI)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_en    (core_en),
    .core_clr   (core_clr),
    .core_z     (core_z),
    .core_ov    (core_ov),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .out_cycles (out_cycles)
  );

  // reference core: a-bit = lo < a, b-bit = hi < b, count AND ones
  logic [RW-1:0] rc_ctr;
  always @(posedge clk) begin
    if (core_clr) begin
      rc_ctr <= '0;
      core_z <= '0;
    end else if (core_en) begin
      rc_ctr <= rc_ctr + 1'b1;
      if (rc_ctr[SW-1:0] < core_a && rc_ctr[RW-1:SW] < core_b)
        core_z <= core_z + 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [SW-1:0] a, input logic [SW-1:0] b);
    int i = 0;
    @(negedge clk);
    while (!in_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("in_ready", 32'(in_ready), 1);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = 0;
    while (!out_valid && l < 5000) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic wait_run();
    int i = 0;
    while (!core_en && i < 10) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("run_start", 32'(core_en), 1);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("ov_drop", 32'(out_valid), 0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    core_ov   = 1'b0;
    out_ready = 1'b0;
    #23;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_core_en", 32'(core_en), 0);
    check("rst_core_clr", 32'(core_clr), 1);
    check("rst_core_a", 32'(core_a), 0);
    check("rst_out_z", 32'(out_z), 0);
    check("rst_out_cycles", 32'(out_cycles), 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("clr_held", 32'(core_clr), 1);
    @(posedge clk);
    #1 check("clr_drop", 32'(core_clr), 0);

    // 32 x 32, latency
    start_op(6'd32, 6'd32);
    #0 check("clear_phase", 32'(core_clr), 1);
    wait_done(lat);
    check("lat_32", lat, 4098);
    check("z_32", 32'(out_z), 1024);
    check("cyc_32", 32'(out_cycles), 4096);
    check("core_a_hold", 32'(core_a), 32);
    release_out();

    // 63 x 63
    start_op(6'd63, 6'd63);
    wait_done(lat);
    check("z_63", 32'(out_z), 3969);
    check("cyc_63", 32'(out_cycles), 4096);
    release_out();

    // zero operand still runs full period
    start_op(6'd0, 6'd45);
    wait_done(lat);
    check("lat_0", lat, 4098);
    check("z_0", 32'(out_z), 0);
    check("cyc_0", 32'(out_cycles), 4096);
    release_out();

    // core_ov raised on RUN cycle 10
    start_op(6'd20, 6'd3);
    wait_run();
    repeat (9) @(posedge clk);
    #1 core_ov = 1'b1;
    @(posedge clk);
    #1 core_ov = 1'b0;
    wait_done(lat);
    check("z_ov", 32'(out_z), OV_Z);
    check("cyc_ov", 32'(out_cycles), OV_CYC);
    release_out();

    // HOLD stall with in_valid pulses
    start_op(6'd7, 6'd9);
    wait_done(lat);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 6'd1;
      in_b     = 6'd1;
      @(posedge clk);
      #1;
      check("stall_valid", 32'(out_valid), 1);
      check("stall_z", 32'(out_z), 63);
      check("stall_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    check("stall_core_a", 32'(core_a), 7);
    release_out();
    @(posedge clk);
    #1 check("stall_no_accept", 32'(core_clr), 0);
    check("stall_core_a2", 32'(core_a), 7);

    // reset mid-RUN
    start_op(6'd5, 6'd7);
    wait_run();
    repeat (99) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid_in_ready", 32'(in_ready), 1);
    check("mid_core_en", 32'(core_en), 0);
    check("mid_core_clr", 32'(core_clr), 1);
    check("mid_core_a", 32'(core_a), 0);
    repeat (5) @(posedge clk);
    #1 check("mid_no_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    start_op(6'd10, 6'd20);
    wait_done(lat);
    check("lat_post", lat, 4098);
    check("z_post", 32'(out_z), 200);
    check("cyc_post", 32'(out_cycles), 4096);
    release_out();

    // back-to-back with out_ready held high
    out_ready = 1'b1;
    start_op(6'd12, 6'd13);
    wait_done(lat);
    check("b2b_valid1", 32'(out_valid), 1);
    check("b2b_z1", 32'(out_z), 156);
    start_op(6'd50, 6'd60);
    wait_done(lat);
    check("b2b_valid2", 32'(out_valid), 1);
    check("b2b_z2", 32'(out_z), 3000);
    check("b2b_cyc2", 32'(out_cycles), 4096);
    @(posedge clk);
    #1 check("b2b_drop", 32'(out_valid), 0);
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
